// File: rtl/arb_grant_fsm_if.sv
// ---------------------------------------------------------------------------
// arb_grant_fsm_if
//   Bundle of request lanes and grant handshake signals for arb_grant_fsm.
//
//   arb_in      [3:0] x 8  per-requester priority code (0 = idle, 15 highest)
//   grant_valid 1          a grant is being offered
//   grant_ready 1          consumer accepts the offered grant
//   grant_id    3          index of the granted requester
//   grant_pri   4          priority of the winner, captured at arbitration
//   timeout     1          one-cycle pulse when an offer is abandoned
//   grant_cnt   8          saturating count of accepted grants
//
//   master : the arbiter (drives the grant side)
//   slave  : requesters and grant consumer
// ---------------------------------------------------------------------------
interface arb_grant_fsm_if;
  logic [3:0] arb_in [7:0];
  logic       grant_valid;
  logic       grant_ready;
  logic [2:0] grant_id;
  logic [3:0] grant_pri;
  logic       timeout;
  logic [7:0] grant_cnt;

  modport master (
    input  arb_in,
    input  grant_ready,
    output grant_valid,
    output grant_id,
    output grant_pri,
    output timeout,
    output grant_cnt
  );

  modport slave (
    output arb_in,
    output grant_ready,
    input  grant_valid,
    input  grant_id,
    input  grant_pri,
    input  timeout,
    input  grant_cnt
  );
endinterface

// File: rtl/arb_grant_fsm.sv
// ---------------------------------------------------------------------------
// arb_grant_fsm
//   Eight-lane priority arbiter with round-robin tie breaking and a
//   valid/ready grant offer that is abandoned after MAX_WAIT cycles.
//
//   Parameters
//     MAX_WAIT  cycles an offer may wait for acceptance (1..255)
//   Ports
//     clk       clock, all state updates on posedge
//     rst_n     asynchronous active-low reset
//     bus       arb_grant_fsm_if.master: arb_in, grant_ready in;
//               grant_valid, grant_id, grant_pri, timeout, grant_cnt out
// ---------------------------------------------------------------------------
module arb_grant_fsm #(
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  arb_grant_fsm_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Last wait count value at which an unaccepted offer is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state_reg;
  logic [2:0] rr_ptr_reg;
  logic [7:0] wait_cnt_reg;
  logic       grant_valid_reg;
  logic [2:0] grant_id_reg;
  logic [3:0] grant_pri_reg;
  logic       timeout_reg;
  logic [7:0] grant_cnt_reg;

  // Lanes carrying X/Z are treated as not requesting. In hardware every bit
  // is 0 or 1, so this only affects simulation.
  logic [3:0] lane_val [7:0];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_val[gi] = $isunknown(bus.arb_in[gi]) ? 4'd0 : bus.arb_in[gi];
    end
  endgenerate

  // Highest value wins. Lanes are scanned starting at rr_ptr and wrapping,
  // and only a strictly greater value replaces the current best, so the
  // first equal-valued lane at or after rr_ptr wins a tie.
  logic [2:0] scan_idx;
  logic [2:0] win_id;
  logic [3:0] win_pri;

  always_comb begin
    scan_idx = rr_ptr_reg;
    win_id   = rr_ptr_reg;
    win_pri  = 4'd0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = rr_ptr_reg + 3'(k);
      if (lane_val[scan_idx] > win_pri) begin
        win_pri = lane_val[scan_idx];
        win_id  = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= 3'd0;
      wait_cnt_reg    <= 8'd0;
      grant_valid_reg <= 1'b0;
      grant_id_reg    <= 3'd0;
      grant_pri_reg   <= 4'd0;
      timeout_reg     <= 1'b0;
      grant_cnt_reg   <= 8'd0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // win_pri of zero means no lane is requesting.
          if (win_pri != 4'd0) begin
            state_reg       <= OFFER;
            grant_valid_reg <= 1'b1;
            grant_id_reg    <= win_id;
            grant_pri_reg   <= win_pri;
            wait_cnt_reg    <= 8'd0;
          end
        end
        OFFER: begin
          // Acceptance is checked first so a last-cycle accept beats timeout.
          if (bus.grant_ready) begin
            state_reg       <= IDLE;
            grant_valid_reg <= 1'b0;
            rr_ptr_reg      <= grant_id_reg + 3'd1;
            if (grant_cnt_reg != 8'd255) begin
              grant_cnt_reg <= grant_cnt_reg + 8'd1;
            end
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg       <= IDLE;
            grant_valid_reg <= 1'b0;
            timeout_reg     <= 1'b1;
            rr_ptr_reg      <= grant_id_reg + 3'd1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant_valid = grant_valid_reg;
  assign bus.grant_id    = grant_id_reg;
  assign bus.grant_pri   = grant_pri_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.grant_cnt   = grant_cnt_reg;

endmodule

// File: tb/tb_arb_grant_fsm.sv
// ---------------------------------------------------------------------------
// tb_arb_grant_fsm
//   Directed bench for arb_grant_fsm (MAX_WAIT = 3). Inputs are driven 1 ns
//   after the rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_arb_grant_fsm;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  arb_grant_fsm_if bus ();

  arb_grant_fsm #(.MAX_WAIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lanes packed 7..0, most significant nibble is lane 7.
  task automatic set_arb(input logic [31:0] v);
    for (int i = 0; i < 8; i++) bus.arb_in[i] = v[i*4 +: 4];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.grant_ready = 1'b0;
    set_arb(32'h0);
    step();
    step();
    vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.grant_valid); end
    vectors++; if (bus.grant_id !== 3'd0) begin miscompares++; $display("FAIL reset_id got %0d want 0", bus.grant_id); end
    vectors++; if (bus.grant_pri !== 4'd0) begin miscompares++; $display("FAIL reset_pri got %0d want 0", bus.grant_pri); end
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
    vectors++; if (bus.grant_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", bus.grant_cnt); end
    rst_n = 1'b1;
    $display("reset done");
  endtask

  task automatic test_basic();
    bus.grant_ready = 1'b1;
    set_arb({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd3});
    vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pre_valid got %b want 0", bus.grant_valid); end
    step();
    set_arb(32'h0);
    vectors++; if (bus.grant_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", bus.grant_valid); end
    vectors++; if (bus.grant_id !== 3'd2) begin miscompares++; $display("FAIL basic_id got %0d want 2", bus.grant_id); end
    vectors++; if (bus.grant_pri !== 4'd5) begin miscompares++; $display("FAIL basic_pri got %0d want 5", bus.grant_pri); end
    step();
    vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drop got %b want 0", bus.grant_valid); end
    vectors++; if (bus.grant_cnt !== 8'd1) begin miscompares++; $display("FAIL basic_cnt got %0d want 1", bus.grant_cnt); end
    $display("basic grant id=%0d pri=%0d cnt=%0d", 2, 5, bus.grant_cnt);
  endtask

  task automatic test_round_robin();
    test_reset();
    bus.grant_ready = 1'b1;
    set_arb(32'h4444_4444);
    for (int k = 0; k < 9; k++) begin
      step();
      vectors++; if (bus.grant_valid !== 1'b1) begin miscompares++; $display("FAIL rr_valid[%0d] got %b want 1", k, bus.grant_valid); end
      vectors++; if (bus.grant_id !== 3'(k % 8)) begin miscompares++; $display("FAIL rr_id[%0d] got %0d want %0d", k, bus.grant_id, k % 8); end
      vectors++; if (bus.grant_cnt !== 8'(k)) begin miscompares++; $display("FAIL rr_cnt_offer[%0d] got %0d want %0d", k, bus.grant_cnt, k); end
      if (k == 8) set_arb(32'h0);
      step();
      vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL rr_bubble[%0d] got %b want 0", k, bus.grant_valid); end
      vectors++; if (bus.grant_cnt !== 8'(k + 1)) begin miscompares++; $display("FAIL rr_cnt[%0d] got %0d want %0d", k, bus.grant_cnt, k + 1); end
      $display("rr grant %0d id=%0d cnt=%0d", k, k % 8, bus.grant_cnt);
    end
  endtask

  // Entered with rr_ptr = 1 and grant_cnt = 9.
  task automatic test_timeout();
    bus.grant_ready = 1'b0;
    set_arb({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0});
    step();
    set_arb(32'h0);
    for (int c = 0; c < 3; c++) begin
      vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd1 || bus.grant_pri !== 4'd9 || bus.timeout !== 1'b0) begin
        miscompares++; $display("FAIL to_offer[%0d] got v=%b id=%0d pri=%0d to=%b want v=1 id=1 pri=9 to=0", c, bus.grant_valid, bus.grant_id, bus.grant_pri, bus.timeout);
      end
      step();
    end
    vectors++; if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b1) begin miscompares++; $display("FAIL to_pulse got v=%b to=%b want v=0 to=1", bus.grant_valid, bus.timeout); end
    vectors++; if (bus.grant_cnt !== 8'd9) begin miscompares++; $display("FAIL to_cnt got %0d want 9", bus.grant_cnt); end
    step();
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL to_pulse_end got %b want 0", bus.timeout); end
    set_arb(32'h4444_4444);
    step();
    set_arb(32'h0);
    vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd2) begin miscompares++; $display("FAIL to_next_id got v=%b id=%0d want v=1 id=2", bus.grant_valid, bus.grant_id); end
    bus.grant_ready = 1'b1;
    step();
    vectors++; if (bus.grant_cnt !== 8'd10) begin miscompares++; $display("FAIL to_after_cnt got %0d want 10", bus.grant_cnt); end
    $display("timeout scenario cnt=%0d", bus.grant_cnt);
  endtask

  // Acceptance on the final wait cycle wins over timeout.
  task automatic test_accept_at_limit();
    bus.grant_ready = 1'b0;
    set_arb({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7});
    step();
    set_arb(32'h0);
    step();
    step();
    vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd0) begin miscompares++; $display("FAIL race_offer got v=%b id=%0d want v=1 id=0", bus.grant_valid, bus.grant_id); end
    bus.grant_ready = 1'b1;
    step();
    vectors++; if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin miscompares++; $display("FAIL race_result got v=%b to=%b want v=0 to=0", bus.grant_valid, bus.timeout); end
    vectors++; if (bus.grant_cnt !== 8'd11) begin miscompares++; $display("FAIL race_cnt got %0d want 11", bus.grant_cnt); end
    $display("accept-at-limit cnt=%0d", bus.grant_cnt);
  endtask

  task automatic test_xz_lanes();
    bus.grant_ready = 1'b1;
    set_arb({4'd0, 4'b000x, 4'bzzzz, 4'bxxxx, 4'd1, 4'd0, 4'd0, 4'd0});
    step();
    vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd3 || bus.grant_pri !== 4'd1) begin
      miscompares++; $display("FAIL xz_grant got v=%b id=%0d pri=%0d want v=1 id=3 pri=1", bus.grant_valid, bus.grant_id, bus.grant_pri);
    end
    set_arb({4'd0, 4'b000x, 4'bzzzz, 4'bxxxx, 4'd0, 4'd0, 4'd0, 4'd0});
    step();
    vectors++; if (bus.grant_cnt !== 8'd12) begin miscompares++; $display("FAIL xz_cnt got %0d want 12", bus.grant_cnt); end
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL xz_idle[%0d] got %b want 0", c, bus.grant_valid); end
    end
    set_arb(32'h0);
    $display("x/z lanes cnt=%0d", bus.grant_cnt);
  endtask

  task automatic test_hold_and_reset();
    bus.grant_ready = 1'b0;
    set_arb({4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
    step();
    set_arb({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15});
    vectors++; if (bus.grant_id !== 3'd6 || bus.grant_pri !== 4'd5) begin miscompares++; $display("FAIL hold_first got id=%0d pri=%0d want id=6 pri=5", bus.grant_id, bus.grant_pri); end
    step();
    vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd6 || bus.grant_pri !== 4'd5) begin
      miscompares++; $display("FAIL hold_stable got v=%b id=%0d pri=%0d want v=1 id=6 pri=5", bus.grant_valid, bus.grant_id, bus.grant_pri);
    end
    bus.grant_ready = 1'b1;
    step();
    vectors++; if (bus.grant_valid !== 1'b0 || bus.grant_cnt !== 8'd13) begin miscompares++; $display("FAIL hold_accept got v=%b cnt=%0d want v=0 cnt=13", bus.grant_valid, bus.grant_cnt); end
    bus.grant_ready = 1'b0;
    step();
    vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd0 || bus.grant_pri !== 4'd15) begin
      miscompares++; $display("FAIL hold_next got v=%b id=%0d pri=%0d want v=1 id=0 pri=15", bus.grant_valid, bus.grant_id, bus.grant_pri);
    end
    bus.grant_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid got %b want 0", bus.grant_valid); end
    vectors++; if (bus.grant_cnt !== 8'd0) begin miscompares++; $display("FAIL async_cnt got %0d want 0", bus.grant_cnt); end
    step();
    vectors++; if (bus.grant_valid !== 1'b0 || bus.grant_cnt !== 8'd0) begin miscompares++; $display("FAIL async_hold got v=%b cnt=%0d want v=0 cnt=0", bus.grant_valid, bus.grant_cnt); end
    set_arb(32'h0);
    rst_n = 1'b1;
    $display("hold and async reset done");
  endtask

  // Entered straight out of reset with grant_cnt = 0.
  task automatic test_saturate();
    bus.grant_ready = 1'b1;
    set_arb({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0});
    for (int k = 1; k <= 258; k++) begin
      step();
      step();
      vectors++; if (bus.grant_cnt !== 8'((k > 255) ? 255 : k)) begin
        miscompares++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, bus.grant_cnt, (k > 255) ? 255 : k);
      end
      if (k >= 254) $display("saturate grant %0d cnt=%0d", k, bus.grant_cnt);
    end
    set_arb(32'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.grant_ready = 1'b0;
    set_arb(32'h0);
    #1;
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_accept_at_limit();
    test_xz_lanes();
    test_hold_and_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_grant_fsm.md
ARB_GRANT_FSM -- requirements
Module: arb_grant_fsm

Interface
REQ-001 Parameter MAX_WAIT, default 15: cycles an offered grant may wait for acceptance before timeout; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 arb_in  input  [3:0] x [7:0] (logic [3:0] arb_in[7:0])  per-requester code; 4'd0 = no request, 4'd1..4'd15 = request at that priority (15 highest).
REQ-005 grant_valid  output  1  a grant is offered.
REQ-006 grant_ready  input  1  consumer accepts the offered grant.
REQ-007 grant_id  output  3  index of the granted requester.
REQ-008 grant_pri  output  4  arb_in value of the winner, captured at arbitration.
REQ-009 timeout  output  1  one-cycle pulse: offer abandoned after MAX_WAIT cycles.
REQ-010 grant_cnt  output  8  count of accepted grants, saturating.

Function
REQ-011 FSM states SHALL be IDLE and OFFER; no other reachable states.
REQ-012 In IDLE, a lane is requesting iff its value is nonzero and contains no X/Z bit; X/Z lanes SHALL be treated as 4'd0 (simulation-only check, no synthesis impact).
REQ-013 In IDLE with at least one requesting lane, the winner SHALL be the lane with the highest value; ties SHALL be broken round-robin, searching upward from rr_ptr and wrapping 7->0.
REQ-014 The winner's index and value SHALL be registered into grant_id/grant_pri on the edge that samples the request; grant_valid SHALL be 1 in the following cycle (latency 1 cycle from sampled request to offer).
REQ-015 In OFFER, grant_valid SHALL remain 1 and grant_id/grant_pri SHALL remain stable until acceptance or timeout, regardless of arb_in changes, including withdrawal of the winning request.
REQ-016 Acceptance = grant_valid && grant_ready at a posedge; on acceptance, FSM -> IDLE, rr_ptr <= grant_id+1 mod 8 (7 wraps to 0), grant_cnt increments unless already 8'd255.
REQ-017 After acceptance, grant_valid SHALL be 0 for exactly one cycle (IDLE bubble) before any new offer; maximum throughput is one grant per 2 cycles.
REQ-018 A wait counter SHALL clear on entering OFFER and increment each OFFER cycle without acceptance; when it reaches MAX_WAIT, FSM -> IDLE, timeout pulses 1 for the next single cycle, rr_ptr <= grant_id+1 mod 8, and grant_cnt SHALL NOT change.
REQ-019 If grant_ready is 1 in the same cycle the counter reaches MAX_WAIT, acceptance SHALL take precedence and timeout SHALL NOT pulse.
REQ-020 grant_ready while grant_valid=0 SHALL be ignored.
REQ-021 With no requesting lane in IDLE, the FSM SHALL stay in IDLE with all state unchanged.
REQ-022 grant_cnt SHALL hold at 8'd255 once saturated; it never wraps.

Reset
REQ-023 While rst_n=0 (asynchronously on assertion): state=IDLE, rr_ptr=0, wait counter=0, grant_valid=0, grant_id=0, grant_pri=0, timeout=0, grant_cnt=0.
REQ-024 Reset asserted during OFFER SHALL drop grant_valid immediately without waiting for a clock edge, and no acceptance SHALL be counted.
REQ-025 First arbitration after reset release SHALL use rr_ptr=0.

Verification
REQ-026 arb_in={0,0,0,0,0,5,0,3} (lanes 7..0), grant_ready=1 -> offer grant_id=2, grant_pri=5 one cycle after sampling; grant_cnt=1.
REQ-027 All lanes = 4'd4, grant_ready held 1 -> grant_id sequence 0,1,2,...,7,0 with one idle cycle between offers; grant_cnt increments by 1 per grant.
REQ-028 MAX_WAIT=3, lane 1=4'd9, grant_ready=0 -> grant_valid high 3 cycles, then timeout=1 for one cycle, grant_cnt unchanged; next grant tie-search starts at lane 2.
REQ-029 Lane 4=4'bxxxx, lane 5=4'bzzzz, lane 6=4'b000x, lane 3=4'd1 -> only lane 3 granted; with lane 3=0, grant_valid stays 0.
REQ-030 Offer pending on lane 6, winner withdraws and lane 0 raises 4'd15 -> grant_id stays 6 until accepted; rst_n pulsed low mid-offer -> grant_valid=0 immediately, grant_cnt=0.
REQ-031 256 accepted grants -> grant_cnt=255 and remains 255 after further grants.
